// File: rtl/morse_symbol_rx_if.sv
// Bundle between the Morse receiver and its consumer: raw button lines in,
// decoded character and status strobes out.
// Handshake: code_valid is a one-cycle strobe with no ready/backpressure; code
// and len are registered on the same edge and hold until the next strobe.
// overflow and conflict are independent one-cycle strobes. fsm_state mirrors
// the receiver FSM (0 IDLE, 1 COLLECT, 2 DISCARD) for debug and checkers.
interface morse_symbol_rx_if #(
    parameter int MAX_LEN = 5
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               btn_dot_n;
    logic               btn_dash_n;
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
    logic               code_valid;
    logic               overflow;
    logic               conflict;
    logic               busy;
    logic [1:0]         fsm_state;

    modport master (
        input  btn_dot_n, btn_dash_n,
        output code, len, code_valid, overflow, conflict, busy, fsm_state
    );

    modport slave (
        output btn_dot_n, btn_dash_n,
        input  code, len, code_valid, overflow, conflict, busy, fsm_state
    );
endinterface

// File: rtl/morse_symbol_rx.sv
// Two-button Morse receiver: synchronises and debounces a dot and a dash
// button, collects up to MAX_LEN symbols per character and closes the
// character after IDLE_TICKS released debounce ticks.
// The bus interface must be instantiated with the same MAX_LEN as this module.
module morse_symbol_rx #(
    parameter int TICK_DIV    = 250000,
    parameter int DEB_SAMPLES = 4,
    parameter int MAX_LEN     = 5,
    parameter int IDLE_TICKS  = 200
) (
    input logic              clk,
    input logic              rst,
    morse_symbol_rx_if.master bus
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEB_W  = $clog2(DEB_SAMPLES + 1);
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_SAMPLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TICKS - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LEN);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    // Channel index 0 = dot, 1 = dash; all internal levels are 1 = pressed.
    logic [TICK_W-1:0]          tick_cnt;
    logic                       tick;
    logic [1:0]                 sync1, sync2;
    logic [1:0]                 deb, deb_prev;
    logic [1:0][DEB_W-1:0]      deb_cnt;

    logic [1:0]                 state;
    logic [MAX_LEN-1:0]         frame;
    logic [LEN_W-1:0]           flen;
    logic [IDLE_W-1:0]          idle_cnt;
    logic [MAX_LEN-1:0]         code_r;
    logic [LEN_W-1:0]           len_r;
    logic                       code_valid_r, overflow_r, conflict_r;

    logic                       dot_evt, dash_evt, single_evt, both_evt, any_evt;
    logic                       btn_down;
    logic [MAX_LEN-1:0]         sym_bit;

    assign tick       = (tick_cnt == TICK_LAST);
    assign dot_evt    = deb[0] & ~deb_prev[0];
    assign dash_evt   = deb[1] & ~deb_prev[1];
    assign single_evt = dot_evt ^ dash_evt;
    assign both_evt   = dot_evt & dash_evt;
    assign any_evt    = dot_evt | dash_evt;
    assign btn_down   = |deb;
    // Symbol bit placed at the next free frame position (dash = 1).
    assign sym_bit    = MAX_LEN'(dash_evt) << flen;

    // Two-flop synchroniser on the inverted (active-high) raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {~bus.btn_dash_n, ~bus.btn_dot_n};
            sync2 <= sync1;
        end
    end

    // Free-running sample tick divider, wraps at TICK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Per-channel debounce: DEB_SAMPLES consecutive differing ticks flip the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb      <= '0;
            deb_prev <= '0;
            deb_cnt  <= '0;
        end else begin
            deb_prev <= deb;
            if (tick) begin
                for (int i = 0; i < 2; i++) begin
                    if (sync2[i] != deb[i]) begin
                        if (deb_cnt[i] == DEB_LAST) begin
                            deb[i]     <= ~deb[i];
                            deb_cnt[i] <= '0;
                        end else begin
                            deb_cnt[i] <= deb_cnt[i] + 1'b1;
                        end
                    end else begin
                        deb_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Character assembly FSM with idle timeout, overflow and conflict strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            frame        <= '0;
            flen         <= '0;
            idle_cnt     <= '0;
            code_r       <= '0;
            len_r        <= '0;
            code_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            conflict_r   <= 1'b0;
        end else begin
            code_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            conflict_r   <= both_evt;
            case (state)
                S_IDLE: begin
                    if (single_evt) begin
                        frame    <= MAX_LEN'(dash_evt);
                        flen     <= LEN_W'(1);
                        idle_cnt <= '0;
                        state    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (single_evt) begin
                        if (flen < LEN_MAX) begin
                            frame    <= frame | sym_bit;
                            flen     <= flen + 1'b1;
                            idle_cnt <= '0;
                        end else begin
                            overflow_r <= 1'b1;
                            frame      <= '0;
                            flen       <= '0;
                            idle_cnt   <= '0;
                            state      <= S_DISCARD;
                        end
                    end else if (tick && !any_evt) begin
                        if (btn_down) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            code_r       <= frame;
                            len_r        <= flen;
                            code_valid_r <= 1'b1;
                            frame        <= '0;
                            flen         <= '0;
                            idle_cnt     <= '0;
                            state        <= S_IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (single_evt) begin
                        idle_cnt <= '0;
                    end else if (tick && !any_evt) begin
                        if (btn_down) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.code       = code_r;
    assign bus.len        = len_r;
    assign bus.code_valid = code_valid_r;
    assign bus.overflow   = overflow_r;
    assign bus.conflict   = conflict_r;
    assign bus.busy       = (state != S_IDLE);
    assign bus.fsm_state  = state;
endmodule

// File: doc/morse_symbol_rx.md
MORSE_SYMBOL_RX -- requirements
Module: morse_symbol_rx

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000; clk cycles per debounce sample tick, minimum 2.
REQ-002 SHALL have parameter DEB_SAMPLES, default 4; consecutive differing tick samples needed to change a debounced state, minimum 1.
REQ-003 SHALL have parameter MAX_LEN, default 5; maximum symbols per character, range 1..8.
REQ-004 SHALL have parameter IDLE_TICKS, default 200; released ticks that close a character, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit; single clock, all state on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 SHALL have port btn_dot_n, input, 1 bit; raw asynchronous dot button, low = pressed.
REQ-008 SHALL have port btn_dash_n, input, 1 bit; raw asynchronous dash button, low = pressed.
REQ-009 SHALL have port code, output, MAX_LEN bits; last completed character, symbol k at bit k, 0 = dot, 1 = dash, unused bits 0.
REQ-010 SHALL have port len, output, clog2(MAX_LEN+1) bits; symbol count of code.
REQ-011 SHALL have port code_valid, output, 1 bit; one-cycle pulse when code/len update.
REQ-012 SHALL have port overflow, output, 1 bit; one-cycle pulse on a symbol beyond MAX_LEN.
REQ-013 SHALL have port conflict, output, 1 bit; one-cycle pulse on simultaneous dot and dash press events.
REQ-014 SHALL have port busy, output, 1 bit; high whenever the FSM is not IDLE.

Function
REQ-015 SHALL pass each raw input through a 2-flop synchroniser clocked every clk cycle.
REQ-016 SHALL count 0..TICK_DIV-1 with wrap and assert an internal tick for one cycle when the count equals TICK_DIV-1.
REQ-017 SHALL, per channel, on each tick: compare synchronised sample to debounced state; if different, increment a channel counter; if equal, clear it; on reaching DEB_SAMPLES, toggle the debounced state and clear the counter.
REQ-018 SHALL generate a one-cycle press event in the cycle a debounced state goes released->pressed; release transitions generate no event.
REQ-019 SHALL, when dot and dash press events occur in the same cycle, discard both, pulse conflict, and leave frame, len and idle counter unchanged.
REQ-020 SHALL implement FSM states IDLE, COLLECT, DISCARD.
REQ-021 SHALL in IDLE: on a single press event, store the symbol at frame bit 0, set frame length 1, clear idle counter, go to COLLECT.
REQ-022 SHALL in COLLECT: on a press event with frame length < MAX_LEN, store the symbol at frame bit [length], increment length, clear idle counter.
REQ-023 SHALL in COLLECT: on a press event with frame length = MAX_LEN, pulse overflow, clear frame and idle counter, go to DISCARD.
REQ-024 SHALL in COLLECT and DISCARD: increment the idle counter on each tick where both debounced states are released and no press event occurs; clear it on any tick where either button is pressed.
REQ-025 SHALL in COLLECT: when the idle counter reaches IDLE_TICKS, register code = frame and len = frame length, pulse code_valid in that same cycle, clear frame, go to IDLE.
REQ-026 SHALL in DISCARD: ignore press events (only clear idle counter); on idle counter reaching IDLE_TICKS, go to IDLE with no code_valid.
REQ-027 SHALL hold code and len stable between code_valid pulses.
REQ-028 SHALL saturate no counter silently: idle counter width covers IDLE_TICKS, debounce counter width covers DEB_SAMPLES.

Reset
REQ-029 SHALL, on rst high, immediately clear synchronisers and debounced states to released, tick and debounce counters, frame, idle counter, code, len, code_valid, overflow, conflict and busy to 0, FSM to IDLE.
REQ-030 SHALL, on rst asserted mid-character, discard the partial frame and emit no code_valid after release.

Verification (TICK_DIV=4, DEB_SAMPLES=3, MAX_LEN=4, IDLE_TICKS=8)
REQ-031 SHALL cover: dot, dash, dot presses each held 10 ticks, then release 8 ticks -> one code_valid, code=4'b0010, len=3.
REQ-032 SHALL cover: 2-tick glitch low on btn_dot_n -> no press event, busy stays 0, no code_valid.
REQ-033 SHALL cover: 5 dash presses -> overflow pulse on 5th, busy stays 1 until 8 released ticks, no code_valid, code/len keep prior values.
REQ-034 SHALL cover: both buttons debounced pressed in the same cycle -> conflict pulse, len unchanged, FSM unchanged.
REQ-035 SHALL cover: rst pulsed after 2 symbols -> busy=0 at once, all outputs 0, no code_valid after 8 idle ticks.
REQ-036 SHALL cover: button held 30 ticks then released -> exactly one symbol stored; idle count starts only after release, code_valid 8 ticks after debounced release.
